// File: rtl/clock_gate_sequencer_if.sv
// rtl/clock_gate_sequencer_if.sv - control/status bundle between the frame sequencer and its host
interface clock_gate_sequencer_if #(
    parameter int ADDR_WIDTH  = 10,
    parameter int GATED_WIDTH = 16
);
    logic                   start;
    logic                   compute_done;
    logic                   en_r;
    logic                   en_w;
    logic [ADDR_WIDTH-1:0]  addr;
    logic [1:0]             phase;
    logic                   busy;
    logic                   done;
    logic [GATED_WIDTH-1:0] gated_cycles;

    modport master (
        output start,
        output compute_done,
        input  en_r,
        input  en_w,
        input  addr,
        input  phase,
        input  busy,
        input  done,
        input  gated_cycles
    );

    modport slave (
        input  start,
        input  compute_done,
        output en_r,
        output en_w,
        output addr,
        output phase,
        output busy,
        output done,
        output gated_cycles
    );
endinterface

// File: rtl/clock_gate_sequencer.sv
// rtl/clock_gate_sequencer.sv - read/compute/write frame sequencer driving clock-gate enables
module clock_gate_sequencer #(
    parameter int READ_COUNT  = 1024,
    parameter int WRITE_COUNT = 1024,
    parameter int ADDR_WIDTH  = 10,
    parameter int GATED_WIDTH = 16
) (
    input  logic                   clk,
    input  logic                   reset,
    clock_gate_sequencer_if.slave  bus
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_READ,
        S_COMPUTE,
        S_WRITE,
        S_DONE
    } state_t;

    // Terminal addresses; a count of 2^ADDR_WIDTH truncates to all-ones and wraps at the boundary.
    localparam logic [ADDR_WIDTH-1:0]  READ_LAST  = ADDR_WIDTH'(READ_COUNT - 1);
    localparam logic [ADDR_WIDTH-1:0]  WRITE_LAST = ADDR_WIDTH'(WRITE_COUNT - 1);
    localparam logic [GATED_WIDTH-1:0] GATED_MAX  = '1;

    state_t                 state_q, state_d;
    logic [ADDR_WIDTH-1:0]  addr_q, addr_d;
    logic [GATED_WIDTH-1:0] gated_q, gated_d;
    logic                   en_r_q, en_r_d;
    logic                   en_w_q, en_w_d;
    logic                   busy_q, busy_d;
    logic                   done_q, done_d;
    logic [1:0]             phase_q, phase_d;

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        gated_d = gated_q;

        case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    state_d = S_READ;
                    addr_d  = '0;
                    gated_d = '0;
                end
            end
            S_READ: begin
                if (addr_q == READ_LAST) begin
                    state_d = S_COMPUTE;
                    addr_d  = '0;
                end else begin
                    addr_d = addr_q + 1'b1;
                end
            end
            S_COMPUTE: begin
                addr_d = '0;
                if (bus.compute_done) begin
                    state_d = S_WRITE;
                end
            end
            S_WRITE: begin
                if (addr_q == WRITE_LAST) begin
                    state_d = S_DONE;
                    addr_d  = '0;
                end else begin
                    addr_d = addr_q + 1'b1;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
                addr_d  = '0;
            end
            default: begin
                state_d = S_IDLE;
                addr_d  = '0;
            end
        endcase

        // Counted against the upcoming state so the count already includes the cycle it is shown in.
        if ((state_d == S_COMPUTE || state_d == S_DONE) && gated_q != GATED_MAX) begin
            gated_d = gated_q + 1'b1;
        end

        // Outputs are decoded from the next state and registered, keeping the gate enables glitch-free.
        en_r_d = (state_d == S_READ);
        en_w_d = (state_d == S_WRITE);
        busy_d = (state_d != S_IDLE);
        done_d = (state_d == S_DONE);
        case (state_d)
            S_READ:    phase_d = 2'd1;
            S_COMPUTE: phase_d = 2'd2;
            S_WRITE:   phase_d = 2'd3;
            default:   phase_d = 2'd0;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            addr_q  <= '0;
            gated_q <= '0;
            en_r_q  <= 1'b0;
            en_w_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            phase_q <= 2'd0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            gated_q <= gated_d;
            en_r_q  <= en_r_d;
            en_w_q  <= en_w_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            phase_q <= phase_d;
        end
    end

    assign bus.en_r         = en_r_q;
    assign bus.en_w         = en_w_q;
    assign bus.addr         = addr_q;
    assign bus.phase        = phase_q;
    assign bus.busy         = busy_q;
    assign bus.done         = done_q;
    assign bus.gated_cycles = gated_q;

endmodule
